systolic_act_feeder: RTL

SYSTOLIC_ACT_FEEDER -- requirements
Module: systolic_act_feeder

---
 rtl/systolic_act_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/systolic_act_feeder.sv
// Activation feeder for a systolic array: buffers input vectors in a small FIFO
// and skews element r of each popped vector by r cycles onto array row r.
module systolic_act_feeder #(
    parameter int N_ROWS     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_ROWS*DATA_WIDTH-1:0]   in_vector,
    input  logic                           in_last,
    input  logic                           stall,
    output logic [N_ROWS*DATA_WIDTH-1:0]   act_out,
    output logic [N_ROWS-1:0]              act_valid,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           tile_done
);
    localparam int VW = N_ROWS * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(N_ROWS);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [VW:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;
    logic [VW-1:0]   head_data;
    logic            head_last;

    assign in_ready   = (count != (AW+1)'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = !stall && (count != '0) && (state_q != DRAIN);
    assign {head_last, head_data} = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_vector};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Row r has an (r+1)-deep line; its tail is the registered act_out for that row.
    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        localparam int unsigned LAST = r;
        logic [DATA_WIDTH-1:0] d_q [LAST+1];
        logic [LAST:0]         v_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned k = 0; k <= LAST; k++) begin
                    d_q[k] <= '0;
                end
                v_q <= '0;
            end else if (!stall) begin
                d_q[0] <= pop ? head_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                v_q[0] <= pop;
                for (int unsigned k = 1; k <= LAST; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign act_out[r*DATA_WIDTH +: DATA_WIDTH] = d_q[LAST];
        assign act_valid[r]                        = v_q[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                IDLE, STREAM: begin
                    if (pop) begin
                        if (head_last) begin
                            state_d = DRAIN;
                            cnt_d   = CW'(N_ROWS - 1);
                        end else begin
                            state_d = STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter hits 0 exactly when the tile's last element sits on the bottom row.
    always_comb begin
        tile_done = (state_q == DRAIN) && (cnt_q == '0) && !stall;
    end

endmodule
